// File: rtl/fifo_access_arbiter.sv
// fifo_access_arbiter
// Arbitrates one shared FIFO_SRL queue between NUM_REQ round-robin enqueue
// requesters and a single dequeue consumer, issuing at most one queue
// operation per cycle. A shadow occupancy count (Count) runs one cycle ahead
// of the queue, so full/empty blocking never depends on the queue's late flags.
//
// Optional build macro: ARB_RD_PRIORITY_EN
//   undefined : read and write alternate when both are possible
//   defined   : a possible read always wins; writes only fill idle read slots
module fifo_access_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int NUM_REQ       = 4
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic [NUM_REQ-1:0]            ReqValid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] ReqData,
  output logic [NUM_REQ-1:0]            ReqReady,
  input  logic                          RdReq,
  output logic                          RdGrant,
  output logic                          RdValid,
  output logic [DATA_WIDTH-1:0]         FifoDataIn,
  output logic                          FifoEnque,
  output logic                          FifoDeque,
  input  logic                          FifoError,
  output logic [ADDRESS_WIDTH:0]        Count,
  output logic                          SyncErr
);

  localparam int FIFO_DEPTH = 1 << ADDRESS_WIDTH;
  localparam int CW         = ADDRESS_WIDTH + 1;
  localparam int PW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  last_op_rd_q, last_op_rd_d;
  logic                  fifo_enque_q, fifo_enque_d;
  logic                  fifo_deque_q, fifo_deque_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  sync_err_q, sync_err_d;
  logic [DATA_WIDTH-1:0] fifo_data_in_q, fifo_data_in_d;

  logic                  sel_found;
  logic [PW-1:0]         sel_idx;
  logic                  wr_cand, rd_cand;
  logic                  do_wr, do_rd;

  // Round-robin search: first valid requester starting at rr_ptr_q.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!sel_found && ReqValid[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
        sel_found = 1'b1;
        sel_idx   = PW'((int'(rr_ptr_q) + i) % NUM_REQ);
      end
    end
  end

  // Candidate qualification and the single-operation decision.
  always_comb begin
    wr_cand = sel_found && (count_q < CW'(FIFO_DEPTH));
    rd_cand = RdReq && (count_q != '0);
    do_wr   = 1'b0;
    do_rd   = 1'b0;
`ifdef ARB_RD_PRIORITY_EN
    do_rd   = rd_cand;
    do_wr   = wr_cand && !rd_cand;
`else
    if (wr_cand && rd_cand) begin
      // Alternate: a write follows a read, a read follows a write.
      do_wr = last_op_rd_q;
      do_rd = !last_op_rd_q;
    end else begin
      do_wr = wr_cand;
      do_rd = rd_cand;
    end
`endif
  end

  // Grants are combinational so the transfer completes at this edge.
  always_comb begin
    ReqReady = '0;
    if (do_wr) begin
      ReqReady[sel_idx] = 1'b1;
    end
    RdGrant = do_rd;
  end

  // Next-state for pointer, shadow count and registered queue controls.
  always_comb begin
    count_d        = count_q;
    rr_ptr_d       = rr_ptr_q;
    last_op_rd_d   = last_op_rd_q;
    fifo_data_in_d = fifo_data_in_q;
    fifo_enque_d   = do_wr;
    fifo_deque_d   = do_rd;
    rd_valid_d     = fifo_deque_q;
    sync_err_d     = sync_err_q | FifoError;
    if (do_wr) begin
      fifo_data_in_d = ReqData[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
      rr_ptr_d       = (sel_idx == PW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
      count_d        = count_q + 1'b1;
      last_op_rd_d   = 1'b0;
    end else if (do_rd) begin
      count_d        = count_q - 1'b1;
      last_op_rd_d   = 1'b1;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count_q        <= '0;
      rr_ptr_q       <= '0;
      last_op_rd_q   <= 1'b0;
      fifo_data_in_q <= '0;
      fifo_enque_q   <= 1'b0;
      fifo_deque_q   <= 1'b0;
      rd_valid_q     <= 1'b0;
      sync_err_q     <= 1'b0;
    end else begin
      count_q        <= count_d;
      rr_ptr_q       <= rr_ptr_d;
      last_op_rd_q   <= last_op_rd_d;
      fifo_data_in_q <= fifo_data_in_d;
      fifo_enque_q   <= fifo_enque_d;
      fifo_deque_q   <= fifo_deque_d;
      rd_valid_q     <= rd_valid_d;
      sync_err_q     <= sync_err_d;
    end
  end

  assign Count      = count_q;
  assign FifoEnque  = fifo_enque_q;
  assign FifoDeque  = fifo_deque_q;
  assign FifoDataIn = fifo_data_in_q;
  assign RdValid    = rd_valid_q;
  assign SyncErr    = sync_err_q;

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// Bench for fifo_access_arbiter (depth 4, three requesters) with a behavioural
// FIFO_SRL queue. Expected queue operations and dequeued words go into
// scoreboard queues when a grant is expected; a monitor pops them whenever the
// arbiter drives FifoEnque/FifoDeque or RdValid.
module tb_fifo_access_arbiter;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int NR = 3;

  logic          Clk;
  logic          Reset_n;
  logic [NR-1:0] ReqValid;
  logic [DW-1:0] req_data [NR];
  logic [NR*DW-1:0] ReqData;
  logic [NR-1:0] ReqReady;
  logic          RdReq;
  logic          RdGrant;
  logic          RdValid;
  logic [DW-1:0] FifoDataIn;
  logic          FifoEnque;
  logic          FifoDeque;
  logic          FifoError;
  logic [AW:0]   Count;
  logic          SyncErr;

  assign ReqData = {req_data[2], req_data[1], req_data[0]};

  fifo_access_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REQ(NR)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .ReqValid(ReqValid), .ReqData(ReqData),
    .ReqReady(ReqReady), .RdReq(RdReq), .RdGrant(RdGrant), .RdValid(RdValid),
    .FifoDataIn(FifoDataIn), .FifoEnque(FifoEnque), .FifoDeque(FifoDeque),
    .FifoError(FifoError), .Count(Count), .SyncErr(SyncErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rd;
    logic [DW-1:0] data;
  } op_t;

  op_t           sb_q[$];
  logic [DW-1:0] rd_exp[$];
  logic [DW-1:0] content[$];

  // Behavioural queue: synchronous reset, registered DataOut and Error.
  logic [DW-1:0] mem_q[$];
  logic [DW-1:0] fifo_dout;
  logic          model_err;
  logic          force_err;
  assign FifoError = model_err | force_err;

  always @(posedge Clk) begin
    if (!Reset_n) begin
      mem_q.delete();
      fifo_dout <= '0;
      model_err <= 1'b0;
    end else begin
      model_err <= 1'b0;
      if (FifoEnque) begin
        if (mem_q.size() >= 4) model_err <= 1'b1;
        else mem_q.push_back(FifoDataIn);
      end
      if (FifoDeque) begin
        if (mem_q.size() == 0) model_err <= 1'b1;
        else fifo_dout <= mem_q.pop_front();
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops scoreboard entries when the arbiter presents queue controls.
  logic prev_deq;
  always @(negedge Clk) begin
    if (!Reset_n) begin
      prev_deq <= 1'b0;
    end else begin
      check("enq_deq_excl", {31'd0, FifoEnque & FifoDeque}, 32'd0);
      if (FifoEnque || FifoDeque) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_op actual enq=%0b deq=%0b required none", FifoEnque, FifoDeque);
        end else begin
          op_t op;
          op = sb_q.pop_front();
          check("op_kind_deq", {31'd0, FifoDeque}, {31'd0, op.rd});
          if (!op.rd) check("fifo_data_in", {24'd0, FifoDataIn}, {24'd0, op.data});
        end
      end
      if (RdValid || prev_deq) begin
        check("rd_valid_latency", {31'd0, RdValid}, {31'd0, prev_deq});
        if (RdValid) begin
          if (rd_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_data_unexpected actual=%0h required none", fifo_dout);
          end else begin
            check("rd_data", {24'd0, fifo_dout}, {24'd0, rd_exp.pop_front()});
          end
        end
      end
      prev_deq <= FifoDeque;
    end
  end

  // One cycle: check grants/count before the edge, record expectations, advance.
  task automatic step(input logic [NR-1:0] exp_rdy, input logic exp_rdg);
    int idx;
    @(negedge Clk);
    check("req_ready", {29'd0, ReqReady}, {29'd0, exp_rdy});
    check("rd_grant", {31'd0, RdGrant}, {31'd0, exp_rdg});
    check("count", {29'd0, Count}, 32'(content.size()));
    if (|exp_rdy) begin
      op_t op;
      idx = 0;
      for (int k = 0; k < NR; k++) if (exp_rdy[k]) idx = k;
      op.rd   = 1'b0;
      op.data = req_data[idx];
      sb_q.push_back(op);
      content.push_back(req_data[idx]);
    end
    if (exp_rdg) begin
      op_t op;
      op.rd   = 1'b1;
      op.data = '0;
      sb_q.push_back(op);
      rd_exp.push_back(content.pop_front());
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    RdReq    = 1'b1;
    ReqValid = '0;
    while (content.size() > 0) step(3'b000, 1'b1);
    RdReq = 1'b0;
    repeat (3) step(3'b000, 1'b0);
  endtask

  bit alt_rd [4];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef ARB_RD_PRIORITY_EN
    alt_rd = '{1'b1, 1'b1, 1'b0, 1'b1};
`else
    alt_rd = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif
    Reset_n   = 1'b1;
    ReqValid  = '0;
    RdReq     = 1'b0;
    force_err = 1'b0;
    for (int k = 0; k < NR; k++) req_data[k] = '0;

    // Reset
    #1 Reset_n = 1'b0;
    #1;
    check("rst_enque", {31'd0, FifoEnque}, 32'd0);
    check("rst_deque", {31'd0, FifoDeque}, 32'd0);
    check("rst_rdvalid", {31'd0, RdValid}, 32'd0);
    check("rst_syncerr", {31'd0, SyncErr}, 32'd0);
    check("rst_count", {29'd0, Count}, 32'd0);
    check("rst_datain", {24'd0, FifoDataIn}, 32'd0);
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    step(3'b000, 1'b0);

    // All three requesters: round-robin 0,1,2,0 then full
    req_data[0] = 8'h11; req_data[1] = 8'h22; req_data[2] = 8'h33;
    ReqValid = 3'b111;
    step(3'b001, 1'b0);
    step(3'b010, 1'b0);
    step(3'b100, 1'b0);
    step(3'b001, 1'b0);
    step(3'b000, 1'b0);
    check("count_full", {29'd0, Count}, 32'd4);
    ReqValid = '0;
    step(3'b000, 1'b0);
    check("syncerr_fill", {31'd0, SyncErr}, 32'd0);
    drain();

    // Empty queue read request, then a single write followed by its read
    RdReq = 1'b1;
    step(3'b000, 1'b0);
    step(3'b000, 1'b0);
    req_data[1] = 8'hA5;
    ReqValid = 3'b010;
    step(3'b010, 1'b0);
    ReqValid = '0;
    step(3'b000, 1'b1);
    RdReq = 1'b0;
    repeat (3) step(3'b000, 1'b0);

    // Count=2 with last op a write, then contention for 4 cycles
    req_data[2] = 8'h44;
    ReqValid = 3'b100;
    step(3'b100, 1'b0);
    req_data[2] = 8'h55;
    step(3'b100, 1'b0);
    req_data[2] = 8'h66;
    RdReq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (alt_rd[i]) step(3'b000, 1'b1);
      else begin
        step(3'b100, 1'b0);
        req_data[2] = req_data[2] + 8'h11;
      end
    end
    ReqValid = '0;
    RdReq    = 1'b0;
`ifdef ARB_RD_PRIORITY_EN
    check("count_contention_end", {29'd0, Count}, 32'd0);
`else
    check("count_contention_end", {29'd0, Count}, 32'd2);
`endif
    drain();
    check("syncerr_normal", {31'd0, SyncErr}, 32'd0);

    // Forced queue error makes SyncErr sticky
    force_err = 1'b1;
    @(negedge Clk);
    check("syncerr_before_edge", {31'd0, SyncErr}, 32'd0);
    @(posedge Clk);
    #1 force_err = 1'b0;
    check("syncerr_set", {31'd0, SyncErr}, 32'd1);
    repeat (3) step(3'b000, 1'b0);
    check("syncerr_sticky", {31'd0, SyncErr}, 32'd1);

    // Mid-cycle async reset while FifoEnque is high; leaves rr pointer at 2 beforehand
    req_data[1] = 8'h5A;
    ReqValid = 3'b010;
    step(3'b010, 1'b0);
    ReqValid = '0;
    check("pre_rst_enque", {31'd0, FifoEnque}, 32'd1);
    check("pre_rst_datain", {24'd0, FifoDataIn}, 32'h5A);
    #2 Reset_n = 1'b0;
    #1;
    check("async_rst_enque", {31'd0, FifoEnque}, 32'd0);
    check("async_rst_datain", {24'd0, FifoDataIn}, 32'd0);
    check("async_rst_count", {29'd0, Count}, 32'd0);
    check("async_rst_syncerr", {31'd0, SyncErr}, 32'd0);
    sb_q.delete();
    rd_exp.delete();
    content.delete();
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    step(3'b000, 1'b0);
    step(3'b000, 1'b0);
    ReqValid = 3'b111;
    step(3'b001, 1'b0);
    drain();

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("rd_exp_empty", 32'(rd_exp.size()), 32'd0);
    check("syncerr_final", {31'd0, SyncErr}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_access_arbiter.md
Name: fifo_access_arbiter

Overview:
- Shares one FIFO_SRL queue instance between NUM_REQ enqueue requesters and a single dequeue consumer.
- Issues at most one operation per cycle: never Enque and Deque together, never Enque when full, never Deque when empty.
- Keeps a shadow occupancy count, so FIFO control outputs can be registered without relying on the queue's one-cycle-late Full/Empty.
- Sits between the producer blocks and the queue; the consumer reads the queue's DataOut directly, qualified by RdValid.

Parameters:
- DATA_WIDTH, 8, data bits per entry; must match the queue.
- ADDRESS_WIDTH, 4, queue address bits; FIFO_DEPTH = 1 << ADDRESS_WIDTH.
- NUM_REQ, 4, number of enqueue requesters, 2..8.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- ReqValid  in  NUM_REQ  per-requester enqueue request.
- ReqData  in  NUM_REQ*DATA_WIDTH  requester k data in bits [k*DATA_WIDTH +: DATA_WIDTH].
- ReqReady  out  NUM_REQ  one-hot grant, combinational.
- RdReq  in  1  consumer dequeue request.
- RdGrant  out  1  dequeue accepted, combinational.
- RdValid  out  1  queue DataOut holds the dequeued word this cycle.
- FifoDataIn  out  DATA_WIDTH  to queue DataIn, registered.
- FifoEnque  out  1  to queue Enque, registered.
- FifoDeque  out  1  to queue Deque, registered.
- FifoError  in  1  from queue Error.
- Count  out  ADDRESS_WIDTH+1  shadow occupancy, 0..FIFO_DEPTH.
- SyncErr  out  1  sticky desync flag.

Behaviour:
- Reset (async, Reset_n=0):
  - FifoEnque, FifoDeque, RdValid, SyncErr, Count, FifoDataIn = 0.
  - Round-robin pointer RrPtr = 0; LastOpRd = 0.
- The queue's sync Reset must be held for at least one Clk edge while Reset_n is low, so that shadow Count and queue contents start consistent.
- Candidates, evaluated each cycle:
  - WrCand = |ReqValid && Count < FIFO_DEPTH.
  - RdCand = RdReq && Count > 0.
- Decision:
  - Only WrCand: write.
  - Only RdCand: read.
  - Both: op opposite to LastOpRd (LastOpRd=1 gives write, LastOpRd=0 gives read).
  - Neither: idle.
- Write select: first k with ReqValid[k]=1, searching RrPtr, RrPtr+1, ... modulo NUM_REQ. ReqReady[k]=1 only for that k.
- Transfer happens at the edge where a grant is high. Requesters hold ReqValid and ReqData stable until their ReqReady is seen.
- At a write edge:
  - FifoEnque<=1 and FifoDataIn<=ReqData[k].
  - RrPtr<=(k+1) mod NUM_REQ; Count<=Count+1; LastOpRd<=0.
- At a read edge:
  - FifoDeque<=1; Count<=Count-1; LastOpRd<=1.
- FifoEnque and FifoDeque are high for exactly one cycle per transfer, and never both.
- Back-to-back transfers are permitted every cycle.
- RdValid<=FifoDeque, i.e. a one-cycle delay.
- Read latency: RdGrant edge N → FifoDeque high cycle N+1 → queue updates DataOut at edge N+1 → RdValid high cycle N+2, with data valid on DataOut.
- Write latency: grant edge N → FifoEnque high cycle N+1 → entry in queue after edge N+1.
- Count lead: Count leads queue occupancy by one cycle. Count=FIFO_DEPTH blocks all writes; Count=0 blocks reads.
- SyncErr <= 1 at any edge where FifoError=1. It is cleared only by reset and should never assert in correct operation.
- Idle cycles leave RrPtr, LastOpRd and Count unchanged.
- ReqValid deasserted without a grant is legal; nothing is recorded.

Optional Feature:
- Macro ARB_RD_PRIORITY_EN.
- Defined:
  - When both candidates exist, read always wins; LastOpRd is unused.
  - Writes proceed only in cycles with no RdCand.
- Undefined: read/write alternation as above.
- Round-robin among writers is identical in both builds.

Test Plan (DATA_WIDTH=8, ADDRESS_WIDTH=2 so depth 4, NUM_REQ=3):
- Reset_n low mid-cycle with FifoEnque=1:
  - Outputs 0 immediately, asynchronously.
  - After release: Count=0, RrPtr=0, no spurious grants.
- ReqValid=3'b111 held, data 0x11/0x22/0x33, RdReq=0:
  - Grants in order k=0,1,2,0; Count reaches 4.
  - ReqReady=0 afterwards; FifoDataIn sequence 0x11,0x22,0x33,0x11.
  - FifoError stays 0 and SyncErr=0.
- Empty queue, RdReq=1:
  - RdGrant=0 and no FifoDeque.
  - Then ReqValid[1]=1 with 0xA5: grant, then read granted next cycle.
  - RdValid asserts 2 cycles after RdGrant with DataOut=0xA5.
- Count=2, ReqValid[2]=1 and RdReq=1 held for 4 cycles, LastOpRd=0:
  - Ops read, write, read, write.
  - FifoEnque and FifoDeque never high together; Count ends 2.
- Same as the previous scenario with ARB_RD_PRIORITY_EN:
  - Read, read; then Count=0 and write, read, alternating.
- Force FifoError=1 for one cycle from the bench:
  - SyncErr=1 and stays 1 until Reset_n pulse.
